// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types for the FPU write-back path.
//   fpu_tag_t  - {flag, addr} that travels with every FPU result
//   wb_entry_t - {data, tag}, one 38-bit write-back buffer entry
//   make_entry - packs the loose result fields into a wb_entry_t
package fpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FP_DATA_W  = 32;

  typedef struct packed {
    logic                  flag;
    logic [REG_ADDR_W-1:0] addr;
  } fpu_tag_t;

  typedef struct packed {
    logic [FP_DATA_W-1:0] data;
    fpu_tag_t             tag;
  } wb_entry_t;

  function automatic wb_entry_t make_entry(
    input logic [FP_DATA_W-1:0]  data,
    input logic                  flag,
    input logic [REG_ADDR_W-1:0] addr
  );
    wb_entry_t e;
    e.data     = data;
    e.tag.flag = flag;
    e.tag.addr = addr;
    return e;
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// fpu_wb_fifo: 2-write / 1-read circular buffer with occupancy count.
//   clk, rst              - clock, synchronous active-high reset
//   i_wr0_en, i_wr0_data  - first write, lands in slot wr_ptr
//   i_wr1_en, i_wr1_data  - second write, lands in slot wr_ptr+1; only
//                           meaningful together with i_wr0_en
//   i_rd_en               - pop the head entry (caller guarantees count != 0)
//   o_head                - entry at rd_ptr
//   o_count               - number of valid entries (0..DEPTH)
// The caller is responsible for never writing more than the free space.
module fpu_wb_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr0_en,
  input  wb_entry_t                  i_wr0_data,
  input  logic                       i_wr1_en,
  input  wb_entry_t                  i_wr1_data,
  input  logic                       i_rd_en,
  output wb_entry_t                  o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [PW-1:0]   w_wr_ptr_p1;
  logic [PW-1:0]   w_push_ptr_inc;
  logic [CW-1:0]   w_push_cnt;
  logic [CW-1:0]   w_pop_cnt;

  // Second write slot wraps naturally because the pointer is exactly PW bits.
  assign w_wr_ptr_p1    = r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
  assign w_push_ptr_inc = {{(PW-1){1'b0}}, i_wr0_en} + {{(PW-1){1'b0}}, i_wr1_en};
  assign w_push_cnt     = {{(CW-1){1'b0}}, i_wr0_en} + {{(CW-1){1'b0}}, i_wr1_en};
  assign w_pop_cnt      = {{(CW-1){1'b0}}, i_rd_en};

  // Storage, pointers and count; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_wr0_en) begin
        r_mem[r_wr_ptr] <= i_wr0_data;
      end
      if (i_wr1_en) begin
        r_mem[w_wr_ptr_p1] <= i_wr1_data;
      end
      r_wr_ptr <= r_wr_ptr + w_push_ptr_inc;
      r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, i_rd_en};
      r_count  <= r_count + w_push_cnt - w_pop_cnt;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fpu_wb_merge.sv
// fpu_wb_merge: merges tagged results from two fixed-latency FPU pipelines
// into one register-file write port through a shared FIFO.
//   clk, rst                          - clock, synchronous active-high reset
//   a_valid/a_data/a_flag/a_addr      - result from port A (fsqrt)
//   b_valid/b_data/b_flag/b_addr      - result from port B (second FPU unit)
//   wb_ready                          - register file accepts a write
//   wb_valid/wb_data/wb_flag/wb_addr  - write request, always the FIFO head
//   almost_full                       - free entries < THRESH; stop issuing
//   overflow                          - sticky, a result was dropped
// When both ports deliver in one cycle A is stored ahead of B; when space
// runs short B is dropped before A.
module fpu_wb_merge
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [31:0]           a_data,
  input  logic                  a_flag,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic                  b_valid,
  input  logic [31:0]           b_data,
  input  logic                  b_flag,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic                  wb_ready,
  output logic                  wb_valid,
  output logic [31:0]           wb_data,
  output logic                  wb_flag,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t     w_a_entry;
  wb_entry_t     w_b_entry;
  wb_entry_t     w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  logic          w_pop;
  logic          w_acc_a;
  logic          w_acc_b;
  logic          w_drop;
  logic          w_wr0_en;
  logic          w_wr1_en;
  wb_entry_t     w_wr0_data;
  wb_entry_t     w_wr1_data;
  logic          r_overflow;

  assign w_a_entry = make_entry(a_data, a_flag, a_addr);
  assign w_b_entry = make_entry(b_data, b_flag, b_addr);

  assign w_pop = wb_valid & wb_ready;

  // The slot freed by this cycle's pop is already usable for a push.
  assign w_free = CW'(DEPTH) - w_count + {{(CW-1){1'b0}}, w_pop};

  // A has priority on space; B needs a second slot only when A also took one.
  assign w_acc_a = a_valid & (w_free != {CW{1'b0}});
  assign w_acc_b = b_valid & (w_acc_a ? (w_free >= CW'(2)) : (w_free != {CW{1'b0}}));
  assign w_drop  = (a_valid & ~w_acc_a) | (b_valid & ~w_acc_b);

  // Map accepted results onto the FIFO's ordered write slots (A ahead of B).
  always_comb begin
    w_wr0_en   = 1'b0;
    w_wr1_en   = 1'b0;
    w_wr0_data = w_a_entry;
    w_wr1_data = w_b_entry;
    if (w_acc_a) begin
      w_wr0_en = 1'b1;
      w_wr1_en = w_acc_b;
    end else if (w_acc_b) begin
      w_wr0_en   = 1'b1;
      w_wr0_data = w_b_entry;
    end else begin
      w_wr0_en = 1'b0;
      w_wr1_en = 1'b0;
    end
  end

  fpu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr0_en   (w_wr0_en),
    .i_wr0_data (w_wr0_data),
    .i_wr1_en   (w_wr1_en),
    .i_wr1_data (w_wr1_data),
    .i_rd_en    (w_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign wb_valid    = (w_count != {CW{1'b0}});
  assign wb_data     = w_head.data;
  assign wb_flag     = w_head.tag.flag;
  assign wb_addr     = w_head.tag.addr;
  assign almost_full = (CW'(DEPTH) - w_count) < CW'(THRESH);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_fpu_wb_merge.sv
module tb_fpu_wb_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [31:0] a_data, b_data;
  logic        a_flag, b_flag;
  logic [4:0]  a_addr, b_addr;
  logic        wb_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        wb_flag;
  logic [4:0]  wb_addr;
  logic        almost_full;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_wb_merge #(.DEPTH(8), .THRESH(6)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_flag(a_flag), .a_addr(a_addr),
    .b_valid(b_valid), .b_data(b_data), .b_flag(b_flag), .b_addr(b_addr),
    .wb_ready(wb_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_flag(wb_flag), .wb_addr(wb_addr),
    .almost_full(almost_full), .overflow(overflow)
  );

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_data = 32'h0; a_flag = 1'b0; a_addr = 5'd0;
    b_valid = 1'b0; b_data = 32'h0; b_flag = 1'b0; b_addr = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    wb_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_almost_full got %0b want 0", almost_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    n_cmp++; if (wb_data !== 32'h0 || wb_flag !== 1'b0 || wb_addr !== 5'd0) begin
      n_bad++; $display("FAIL reset_head got %h/%0b/%0d want 0/0/0", wb_data, wb_flag, wb_addr);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL idle_wb_valid cycle %0d got %0b want 0", i, wb_valid); end
    end
  endtask

  task automatic test_single();
    wb_ready = 1'b1;
    a_valid = 1'b1; a_data = 32'h3F800000; a_flag = 1'b1; a_addr = 5'd5;
    step();
    idle_inputs();
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0b want 1", wb_valid); end
    n_cmp++; if (wb_data !== 32'h3F800000 || wb_flag !== 1'b1 || wb_addr !== 5'd5) begin
      n_bad++; $display("FAIL single_entry got %h/%0b/%0d want 3f800000/1/5", wb_data, wb_flag, wb_addr);
    end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle got %0b want 0", wb_valid); end
  endtask

  task automatic test_pair_order();
    wb_ready = 1'b1;
    a_valid = 1'b1; a_data = 32'h40000000; a_flag = 1'b0; a_addr = 5'd1;
    b_valid = 1'b1; b_data = 32'h40400000; b_flag = 1'b1; b_addr = 5'd2;
    step();
    idle_inputs();
    n_cmp++; if (wb_valid !== 1'b1 || wb_addr !== 5'd1 || wb_data !== 32'h40000000 || wb_flag !== 1'b0) begin
      n_bad++; $display("FAIL pair_first got v%0b %h/%0b/%0d want v1 40000000/0/1", wb_valid, wb_data, wb_flag, wb_addr);
    end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 32'h40400000 || wb_flag !== 1'b1) begin
      n_bad++; $display("FAIL pair_second got v%0b %h/%0b/%0d want v1 40400000/1/2", wb_valid, wb_data, wb_flag, wb_addr);
    end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL pair_drained got %0b want 0", wb_valid); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rcv  = 0;
    wb_ready = 1'b0;
    for (int cyc = 0; cyc < 200 && rcv < 20; cyc++) begin
      wb_ready = cyc[0];
      a_valid  = (sent < 20) && !almost_full;
      a_data   = 32'(sent);
      a_addr   = 5'(sent % 32);
      a_flag   = 1'b0;
      if (wb_valid && wb_ready) begin
        n_cmp++;
        if (wb_data !== 32'(rcv) || wb_addr !== 5'(rcv % 32)) begin
          n_bad++; $display("FAIL wrap_seq index %0d got %0d/%0d want %0d/%0d", rcv, wb_data, wb_addr, rcv, rcv % 32);
        end
        rcv++;
      end
      if (a_valid) sent++;
      step();
    end
    idle_inputs();
    n_cmp++; if (rcv != 20) begin n_bad++; $display("FAIL wrap_count got %0d want 20", rcv); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_no_dup got %0b want 0", wb_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_fill_overflow();
    wb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_data = 32'h100 + 32'(2*k);     a_flag = 1'b0; a_addr = 5'(2*k);
      b_valid = 1'b1; b_data = 32'h100 + 32'(2*k + 1); b_flag = 1'b1; b_addr = 5'(2*k + 1);
      if (k == 4) begin
        a_data = 32'hFFFF0000; b_data = 32'hFFFF0001;
      end
      step();
      if (k == 0) begin
        n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL fill_af_count2 got %0b want 0", almost_full); end
      end
      if (k == 1) begin
        n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL fill_af_count4 got %0b want 1", almost_full); end
      end
      if (k == 3) begin
        n_cmp++; if (dut.u_fifo.r_count !== 4'd8) begin n_bad++; $display("FAIL fill_count8 got %0d want 8", dut.u_fifo.r_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_no_ovf_yet got %0b want 0", overflow); end
      end
      if (k == 4) begin
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_overflow got %0b want 1", overflow); end
        n_cmp++; if (dut.u_fifo.r_count !== 4'd8) begin n_bad++; $display("FAIL fill_still8 got %0d want 8", dut.u_fifo.r_count); end
      end
    end
    idle_inputs();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h100 + 32'(i) || wb_addr !== 5'(i) || wb_flag !== i[0]) begin
        n_bad++; $display("FAIL drain_entry %0d got v%0b %h/%0b/%0d want v1 %h/%0b/%0d",
                          i, wb_valid, wb_data, wb_flag, wb_addr, 32'h100 + 32'(i), i[0], i);
      end
      step();
    end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got %0b want 0", wb_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL drain_ovf_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_mid_reset();
    wb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_data = 32'h500 + 32'(k); a_flag = 1'b0; a_addr = 5'(k);
      step();
    end
    n_cmp++; if (dut.u_fifo.r_count !== 4'd5) begin n_bad++; $display("FAIL mrst_pre_count got %0d want 5", dut.u_fifo.r_count); end
    // Keep A valid during reset: it must be ignored.
    a_data = 32'h12345678;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %0b want 0", wb_valid); end
    n_cmp++; if (dut.u_fifo.r_count !== 4'd0) begin n_bad++; $display("FAIL mrst_count got %0d want 0", dut.u_fifo.r_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mrst_overflow got %0b want 0", overflow); end
    wb_ready = 1'b1;
    a_valid = 1'b1; a_data = 32'hDEADBEEF; a_flag = 1'b1; a_addr = 5'd9;
    step();
    idle_inputs();
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_flag !== 1'b1 || wb_addr !== 5'd9) begin
      n_bad++; $display("FAIL mrst_new got v%0b %h/%0b/%0d want v1 deadbeef/1/9", wb_valid, wb_data, wb_flag, wb_addr);
    end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_new_drained got %0b want 0", wb_valid); end
  endtask

  initial begin
    rst = 1'b1;
    wb_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_pair_order();
    test_wrap();
    test_fill_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
